gate_scanner: RTL and testbench
===============================

Name: gate_scanner

Overview:
- Read-side counterpart of the gate-drawing block: walks the same LENGTH-pixel horizontal or vertical segment, reading pixel colours from the video memory read port instead of writing them.
- Reports whether any pixel on the segment matches a target colour, and the offset of the first match.
- Used by the character/collision logic to test whether a gate already occupies a path.
- Sits between the game control FSM (enable/done handshake) and the pixel memory read port.

Parameters:
- LENGTH, 15, number of pixels scanned from the start coordinate (1..255).
- READ_LATENCY, 1, cycles from memRead asserted to memColour valid (1..4, fixed pipeline).
- OFS_W, 8, width of hitOffset; must satisfy 2^OFS_W > LENGTH.

Ports:
- iClock  input  1  system clock, rising edge.
- iResetn  input  1  reset, asynchronous, active-low.
- enable  input  1  level request; held high for the whole scan, dropped to release.
- x  input  11  start column, sampled on scan start.
- y  input  11  start row, sampled on scan start.
- vertical  input  1  1 = step y, 0 = step x; sampled on scan start.
- iColour  input  3  target colour; sampled on scan start.
- memX  output  11  read address column.
- memY  output  11  read address row.
- memRead  output  1  read strobe, one pixel per cycle.
- memColour  input  3  read data, valid READ_LATENCY cycles after its memRead.
- done  output  1  scan complete; held while enable high.
- hit  output  1  a matching pixel was found; valid when done=1.
- hitOffset  output  OFS_W  offset (0..LENGTH-1) of first match; 0 when hit=0.

Behaviour:
- Reset (async, iResetn=0): state IDLE; memRead=0, memX=0, memY=0, done=0, hit=0, hitOffset=0; valid pipeline cleared.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: enable=1 -> latch x, y, vertical, iColour; issue counter=0; go to ISSUE. Outputs stay at 0 in IDLE.
- ISSUE:
  - Each cycle drive memRead=1 with memX/memY = start + issue counter along the selected axis; counter+1.
  - After LENGTH reads, or on the first cycle a hit is registered, stop issuing (memRead=0) and go to DRAIN.
- Read pipeline:
  - A READ_LATENCY-deep shift register carries valid plus the offset of each read.
  - When a valid return has memColour == latched iColour and hit=0: set hit=1 and capture that offset into hitOffset.
  - Returns after the first hit are ignored.
  - The first match is always the lowest offset, since returns arrive in order.
- DRAIN: wait until the pipeline holds no valid entries, then go to DONE.
- DONE: done=1; hit and hitOffset stable. Stay while enable=1.
- enable=0 in any non-IDLE state:
  - Next cycle go to IDLE; done, hit, hitOffset, memRead cleared.
  - Pipeline flushed; in-flight returns ignored.
  - A new scan needs enable low for at least one cycle.
- Latency:
  - No hit: done rises LENGTH + READ_LATENCY + 1 cycles after the enable edge is sampled.
  - Early hit at offset k: memRead stays high for k + READ_LATENCY + 1 cycles (it stops the cycle after the hit registers), then the pipeline drains.
- Arithmetic: coordinates are 11-bit unsigned and wrap mod 2048 with no clamping. The issue counter width is OFS_W.
- Inputs x, y, vertical and iColour changing mid-scan have no effect.
- Simultaneous cases:
  - A hit on the return for the final read issued: normal DRAIN.
  - enable drop in the same cycle as a DRAIN->DONE transition: abort wins, done stays 0.

Decomposition:
- Shared game package holds:
  - Colour constants (BLACK=3'b000, gate colours).
  - COORD_W=11.
  - The state enum for this FSM, so the control FSM can reference it in assertions.
- One natural sub-module: scan_read_pipe, the READ_LATENCY-deep valid/offset shift register with flush input.
- The address stepper and compare logic stay in gate_scanner.

Test Plan:
- Horizontal, no match:
  - Stimulus: x=100, y=50, vertical=0, iColour=3'b100, memory all 3'b000.
  - Required: memRead for 15 cycles with memX=100..114 and memY=50; done after 17 cycles; hit=0, hitOffset=0.
- Vertical, match:
  - Stimulus: x=20, y=200, vertical=1, iColour=3'b010, pixel (20,207)=3'b010.
  - Required: hit=1, hitOffset=7; memRead deasserts after reading y=208 (memRead high for 9 cycles); done=1.
- Two matches:
  - Stimulus: matches at offsets 3 and 5.
  - Required: hitOffset=3.
- Wrap:
  - Stimulus: x=2040, vertical=0, LENGTH=15.
  - Required: memX sequence 2040..2047, 0..6.
- Abort:
  - Stimulus: drop enable at the 5th ISSUE cycle; a later return would have matched.
  - Required: next cycle memRead=0, done=0, hit=0; re-enable scans cleanly from the new x/y.
- Async reset mid-scan:
  - Stimulus: pull iResetn low between clock edges.
  - Required: all outputs 0 immediately, without waiting for an edge; state IDLE; READ_LATENCY=3 variant repeats the no-match case with done after 19 cycles.

Source files
------------

// File: rtl/gate_scanner_pkg.sv
// Shared game definitions: coordinate width, palette and the
// gate scanner FSM state encoding.
package gate_scanner_pkg;

    localparam int COORD_W = 11;

    localparam logic [2:0] BLACK      = 3'b000;
    localparam logic [2:0] GATE_RED   = 3'b100;
    localparam logic [2:0] GATE_GREEN = 3'b010;
    localparam logic [2:0] GATE_BLUE  = 3'b001;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } scan_state_e;

    function automatic logic [COORD_W-1:0] step_coord(
        input logic [COORD_W-1:0] base,
        input logic [COORD_W-1:0] ofs,
        input logic               on
    );
        return on ? base + ofs : base;
    endfunction

endpackage

// File: rtl/scan_read_pipe.sv
// Valid/offset shift register tracking reads in flight through the
// fixed-latency pixel memory; flush drops everything in flight.
module scan_read_pipe #(
    parameter int LAT   = 1,
    parameter int OFS_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [OFS_W-1:0] push_ofs,
    input  logic             flush,
    output logic             out_valid,
    output logic [OFS_W-1:0] out_ofs,
    output logic             busy
);

    logic [LAT-1:0]            vld_q, vld_d;
    logic [LAT-1:0][OFS_W-1:0] ofs_q, ofs_d;

    always_comb begin
        vld_d    = '0;
        ofs_d    = ofs_q;
        vld_d[0] = push & ~flush;
        ofs_d[0] = push_ofs;
        for (int i = 1; i < LAT; i++) begin
            vld_d[i] = vld_q[i-1] & ~flush;
            ofs_d[i] = ofs_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            ofs_q <= '0;
        end else begin
            vld_q <= vld_d;
            ofs_q <= ofs_d;
        end
    end

    assign out_valid = vld_q[LAT-1];
    assign out_ofs   = ofs_q[LAT-1];
    assign busy      = |vld_q;

endmodule

// File: rtl/gate_scanner.sv
// Walks a horizontal/vertical pixel segment through the video memory
// read port and reports the first pixel matching a target colour.
module gate_scanner
    import gate_scanner_pkg::*;
#(
    parameter int LENGTH       = 15,
    parameter int READ_LATENCY = 1,
    parameter int OFS_W        = 8
) (
    input  logic             iClock,
    input  logic             iResetn,
    input  logic             enable,
    input  logic [10:0]      x,
    input  logic [10:0]      y,
    input  logic             vertical,
    input  logic [2:0]       iColour,
    output logic [10:0]      memX,
    output logic [10:0]      memY,
    output logic             memRead,
    input  logic [2:0]       memColour,
    output logic             done,
    output logic             hit,
    output logic [OFS_W-1:0] hitOffset
);

    localparam logic [OFS_W-1:0] LAST = OFS_W'(LENGTH - 1);

    scan_state_e          state_q, state_d;
    logic [COORD_W-1:0]   x_q, x_d, y_q, y_d;
    logic                 vert_q, vert_d;
    logic [2:0]           col_q, col_d;
    logic [OFS_W-1:0]     cnt_q, cnt_d;
    logic                 hit_q, hit_d;
    logic [OFS_W-1:0]     hofs_q, hofs_d;

    logic                 push, flush;
    logic                 ret_valid, pipe_busy, hit_new;
    logic [OFS_W-1:0]     ret_ofs;
    logic [COORD_W-1:0]   step;

    assign step    = COORD_W'(cnt_q);
    assign hit_new = ret_valid && (memColour == col_q) && !hit_q;

    scan_read_pipe #(
        .LAT   (READ_LATENCY),
        .OFS_W (OFS_W)
    ) u_pipe (
        .clk       (iClock),
        .rst_n     (iResetn),
        .push      (push),
        .push_ofs  (cnt_q),
        .flush     (flush),
        .out_valid (ret_valid),
        .out_ofs   (ret_ofs),
        .busy      (pipe_busy)
    );

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        vert_d  = vert_q;
        col_d   = col_q;
        cnt_d   = cnt_q;
        hit_d   = hit_q;
        hofs_d  = hofs_q;
        memRead = 1'b0;
        memX    = '0;
        memY    = '0;
        done    = 1'b0;
        push    = 1'b0;
        flush   = 1'b0;

        // Returns arrive in issue order, so the first hit is the lowest offset.
        if (hit_new) begin
            hit_d  = 1'b1;
            hofs_d = ret_ofs;
        end

        case (state_q)
            S_IDLE: begin
                hit_d  = 1'b0;
                hofs_d = '0;
                if (enable) begin
                    x_d     = x;
                    y_d     = y;
                    vert_d  = vertical;
                    col_d   = iColour;
                    cnt_d   = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                memRead = 1'b1;
                memX    = step_coord(x_q, step, !vert_q);
                memY    = step_coord(y_q, step, vert_q);
                push    = 1'b1;
                if (hit_new || cnt_q == LAST) begin
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + OFS_W'(1);
                end
            end
            S_DRAIN: begin
                if (!pipe_busy) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // Releasing enable always wins, even over a pending DONE.
        if (state_q != S_IDLE && !enable) begin
            state_d = S_IDLE;
            flush   = 1'b1;
            hit_d   = 1'b0;
            hofs_d  = '0;
        end
    end

    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            vert_q  <= 1'b0;
            col_q   <= BLACK;
            cnt_q   <= '0;
            hit_q   <= 1'b0;
            hofs_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            vert_q  <= vert_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
            hofs_q  <= hofs_d;
        end
    end

    assign hit       = hit_q;
    assign hitOffset = hofs_q;

endmodule

// File: tb/tb_gate_scanner.sv
// Directed bench for gate_scanner: one-cycle and three-cycle read
// latency instances against a small sparse pixel memory model.
module tb_gate_scanner;
    import gate_scanner_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        en_a, en_b;
    logic [10:0] x_i, y_i;
    logic        vert_i;
    logic [2:0]  col_i;

    logic [10:0] a_memX, a_memY, b_memX, b_memY;
    logic        a_memRead, b_memRead;
    logic [2:0]  a_memColour, b_memColour;
    logic        a_done, b_done, a_hit, b_hit;
    logic [7:0]  a_off, b_off;

    int checks = 0;
    int errors = 0;

    logic        m0_en, m1_en;
    logic [10:0] m0x, m0y, m1x, m1y;
    logic [2:0]  mcol;
    logic [2:0]  bd0, bd1;

    logic [10:0] qx[$];
    logic [10:0] qy[$];

    bit          sel;
    logic        s_memRead, s_done, s_hit;
    logic [10:0] s_memX, s_memY;
    logic [7:0]  s_off;

    assign s_memRead = sel ? b_memRead : a_memRead;
    assign s_memX    = sel ? b_memX : a_memX;
    assign s_memY    = sel ? b_memY : a_memY;
    assign s_done    = sel ? b_done : a_done;
    assign s_hit     = sel ? b_hit : a_hit;
    assign s_off     = sel ? b_off : a_off;

    gate_scanner #(.LENGTH(15), .READ_LATENCY(1), .OFS_W(8)) a_dut (
        .iClock(clk), .iResetn(rst_n), .enable(en_a),
        .x(x_i), .y(y_i), .vertical(vert_i), .iColour(col_i),
        .memX(a_memX), .memY(a_memY), .memRead(a_memRead),
        .memColour(a_memColour), .done(a_done), .hit(a_hit),
        .hitOffset(a_off)
    );

    gate_scanner #(.LENGTH(15), .READ_LATENCY(3), .OFS_W(8)) b_dut (
        .iClock(clk), .iResetn(rst_n), .enable(en_b),
        .x(x_i), .y(y_i), .vertical(vert_i), .iColour(col_i),
        .memX(b_memX), .memY(b_memY), .memRead(b_memRead),
        .memColour(b_memColour), .done(b_done), .hit(b_hit),
        .hitOffset(b_off)
    );

    function automatic logic [2:0] pix(input logic [10:0] px, input logic [10:0] py);
        if (m0_en && px == m0x && py == m0y) return mcol;
        if (m1_en && px == m1x && py == m1y) return mcol;
        return BLACK;
    endfunction

    always @(posedge clk) begin
        a_memColour <= a_memRead ? pix(a_memX, a_memY) : BLACK;
        bd0         <= b_memRead ? pix(b_memX, b_memY) : BLACK;
        bd1         <= bd0;
        b_memColour <= bd1;
    end

    task automatic do_scan(input bit s, input logic [10:0] sx, input logic [10:0] sy,
                           input logic sv, input logic [2:0] sc,
                           output int nr, output int lat);
        qx.delete();
        qy.delete();
        nr = 0;
        lat = -1;
        sel = s;
        x_i = sx; y_i = sy; vert_i = sv; col_i = sc;
        if (s) en_b = 1'b1; else en_a = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 200; k++) begin
            if (s_memRead) begin
                nr++;
                qx.push_back(s_memX);
                qy.push_back(s_memY);
            end
            if (s_done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic drop_enable();
        en_a = 1'b0;
        en_b = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic clear_matches();
        m0_en = 1'b0; m1_en = 1'b0;
        m0x = '0; m0y = '0; m1x = '0; m1y = '0; mcol = BLACK;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0;
        x_i = '0; y_i = '0; vert_i = 1'b0; col_i = '0;
        clear_matches();
        repeat (2) @(negedge clk);
        checks++; if (a_memRead !== 1'b0) begin errors++; $display("FAIL reset_memRead: got %b want 0", a_memRead); end
        checks++; if (a_memX !== 11'd0 || a_memY !== 11'd0) begin errors++; $display("FAIL reset_addr: got %0d,%0d want 0,0", a_memX, a_memY); end
        checks++; if (a_done !== 1'b0 || a_hit !== 1'b0) begin errors++; $display("FAIL reset_done_hit: got %b%b want 00", a_done, a_hit); end
        checks++; if (a_off !== 8'd0) begin errors++; $display("FAIL reset_off: got %0d want 0", a_off); end
        checks++; if (b_memRead !== 1'b0 || b_done !== 1'b0) begin errors++; $display("FAIL reset_b: got %b%b want 00", b_memRead, b_done); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_horizontal();
        int nr, lat, bad;
        clear_matches();
        do_scan(0, 11'd100, 11'd50, 1'b0, 3'b100, nr, lat);
        checks++; if (nr !== 15) begin errors++; $display("FAIL horiz_reads: got %0d want 15", nr); end
        checks++; if (lat !== 17) begin errors++; $display("FAIL horiz_done_lat: got %0d want 17", lat); end
        checks++; if (a_hit !== 1'b0 || a_off !== 8'd0) begin errors++; $display("FAIL horiz_hit: got %b/%0d want 0/0", a_hit, a_off); end
        bad = 0;
        for (int i = 0; i < qx.size(); i++) begin
            if (qx[i] !== 11'(100 + i) || qy[i] !== 11'd50) bad++;
        end
        checks++; if (bad !== 0 || qx.size() == 0) begin errors++; $display("FAIL horiz_addr: got %0d bad of %0d want 0 bad", bad, qx.size()); end
        en_a = 1'b0;
        @(negedge clk);
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL horiz_release: done got %b want 0", a_done); end
        @(negedge clk);
    endtask

    task automatic test_vertical_hit();
        int nr, lat;
        clear_matches();
        m0_en = 1'b1; m0x = 11'd20; m0y = 11'd207; mcol = 3'b010;
        do_scan(0, 11'd20, 11'd200, 1'b1, 3'b010, nr, lat);
        checks++; if (a_hit !== 1'b1 || a_off !== 8'd7) begin errors++; $display("FAIL vert_hit: got %b/%0d want 1/7", a_hit, a_off); end
        checks++; if (nr !== 9) begin errors++; $display("FAIL vert_reads: got %0d want 9", nr); end
        checks++; if (nr < 1 || qy[nr-1] !== 11'd208 || qx[0] !== 11'd20) begin errors++; $display("FAIL vert_last_addr: got %0d reads want last y 208 x 20", nr); end
        checks++; if (lat !== 11) begin errors++; $display("FAIL vert_done_lat: got %0d want 11", lat); end
        drop_enable();
    endtask

    task automatic test_last_pixel();
        int nr, lat;
        clear_matches();
        m0_en = 1'b1; m0x = 11'd14; m0y = 11'd0; mcol = 3'b100;
        do_scan(0, 11'd0, 11'd0, 1'b0, 3'b100, nr, lat);
        checks++; if (a_hit !== 1'b1 || a_off !== 8'd14) begin errors++; $display("FAIL last_hit: got %b/%0d want 1/14", a_hit, a_off); end
        checks++; if (nr !== 15 || lat !== 17) begin errors++; $display("FAIL last_timing: got %0d reads lat %0d want 15/17", nr, lat); end
        drop_enable();
    endtask

    task automatic test_two_matches();
        int nr, lat;
        clear_matches();
        m0_en = 1'b1; m0x = 11'd303; m0y = 11'd10;
        m1_en = 1'b1; m1x = 11'd305; m1y = 11'd10; mcol = 3'b001;
        do_scan(0, 11'd300, 11'd10, 1'b0, 3'b001, nr, lat);
        checks++; if (a_hit !== 1'b1 || a_off !== 8'd3) begin errors++; $display("FAIL two_hit: got %b/%0d want 1/3", a_hit, a_off); end
        checks++; if (nr !== 5) begin errors++; $display("FAIL two_reads: got %0d want 5", nr); end
        drop_enable();
    endtask

    task automatic test_wrap();
        int nr, lat, bad;
        clear_matches();
        do_scan(0, 11'd2040, 11'd5, 1'b0, 3'b100, nr, lat);
        bad = 0;
        for (int i = 0; i < qx.size(); i++) begin
            if (qx[i] !== 11'(2040 + i)) bad++;
        end
        checks++; if (bad !== 0 || nr !== 15) begin errors++; $display("FAIL wrap_addr: got %0d bad, %0d reads want 0/15", bad, nr); end
        checks++; if (nr < 15 || qx[8] !== 11'd0 || qx[14] !== 11'd6) begin errors++; $display("FAIL wrap_edge: got %0d reads want x[8]=0 x[14]=6", nr); end
        drop_enable();
    endtask

    task automatic test_abort();
        int nr, lat;
        clear_matches();
        m0_en = 1'b1; m0x = 11'd504; m0y = 11'd600; mcol = 3'b011;
        sel = 0;
        x_i = 11'd500; y_i = 11'd600; vert_i = 1'b0; col_i = 3'b011;
        en_a = 1'b1;
        @(negedge clk);
        repeat (4) @(negedge clk);
        checks++; if (a_memRead !== 1'b1 || a_memX !== 11'd504) begin errors++; $display("FAIL abort_pre: got rd %b x %0d want 1/504", a_memRead, a_memX); end
        en_a = 1'b0;
        @(negedge clk);
        checks++; if (a_memRead !== 1'b0 || a_done !== 1'b0 || a_hit !== 1'b0) begin errors++; $display("FAIL abort_clear: got %b%b%b want 000", a_memRead, a_done, a_hit); end
        repeat (3) @(negedge clk);
        checks++; if (a_hit !== 1'b0 || a_off !== 8'd0) begin errors++; $display("FAIL abort_flush: got %b/%0d want 0/0", a_hit, a_off); end
        do_scan(0, 11'd700, 11'd30, 1'b0, 3'b011, nr, lat);
        checks++; if (nr !== 15 || lat !== 17) begin errors++; $display("FAIL abort_rescan: got %0d reads lat %0d want 15/17", nr, lat); end
        checks++; if (nr < 1 || qx[0] !== 11'd700 || qy[0] !== 11'd30 || a_hit !== 1'b0) begin errors++; $display("FAIL abort_rescan_addr: got %0d reads hit %b want 700,30 no hit", nr, a_hit); end
        drop_enable();
    endtask

    task automatic test_async_reset();
        int nr, lat;
        clear_matches();
        m0_en = 1'b1; m0x = 11'd20; m0y = 11'd207; mcol = 3'b010;
        do_scan(0, 11'd20, 11'd200, 1'b1, 3'b010, nr, lat);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (a_done !== 1'b0 || a_hit !== 1'b0 || a_off !== 8'd0) begin errors++; $display("FAIL arst_done: got %b%b/%0d want 00/0", a_done, a_hit, a_off); end
        en_a = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_matches();
        sel = 0;
        x_i = 11'd900; y_i = 11'd40; vert_i = 1'b0; col_i = 3'b100;
        en_a = 1'b1;
        @(negedge clk);
        repeat (3) @(negedge clk);
        checks++; if (a_memRead !== 1'b1 || a_memX !== 11'd903) begin errors++; $display("FAIL arst_pre: got rd %b x %0d want 1/903", a_memRead, a_memX); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (a_memRead !== 1'b0 || a_memX !== 11'd0 || a_memY !== 11'd0) begin errors++; $display("FAIL arst_issue: got rd %b x %0d y %0d want 0/0/0", a_memRead, a_memX, a_memY); end
        checks++; if (a_dut.state_q !== S_IDLE) begin errors++; $display("FAIL arst_state: got %0d want %0d", a_dut.state_q, S_IDLE); end
        en_a = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_latency3();
        int nr, lat;
        clear_matches();
        do_scan(1, 11'd100, 11'd50, 1'b0, 3'b100, nr, lat);
        checks++; if (nr !== 15 || lat !== 19) begin errors++; $display("FAIL lat3_nohit: got %0d reads lat %0d want 15/19", nr, lat); end
        checks++; if (b_hit !== 1'b0 || qx.size() < 15 || qx[14] !== 11'd114) begin errors++; $display("FAIL lat3_nohit_addr: got hit %b reads %0d want 0, last x 114", b_hit, qx.size()); end
        drop_enable();
        m0_en = 1'b1; m0x = 11'd20; m0y = 11'd207; mcol = 3'b010;
        do_scan(1, 11'd20, 11'd200, 1'b1, 3'b010, nr, lat);
        checks++; if (b_hit !== 1'b1 || b_off !== 8'd7) begin errors++; $display("FAIL lat3_hit: got %b/%0d want 1/7", b_hit, b_off); end
        checks++; if (nr !== 11 || lat !== 15) begin errors++; $display("FAIL lat3_hit_timing: got %0d reads lat %0d want 11/15", nr, lat); end
        drop_enable();
    endtask

    initial begin
        sel = 0;
        test_reset();
        test_horizontal();
        test_vertical_hit();
        test_last_pixel();
        test_two_matches();
        test_wrap();
        test_abort();
        test_async_reset();
        test_latency3();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
